// File: rtl/rx_buffer_pkg.sv
// Shared UART constants: data width, receive-buffer defaults and capture FSM encodings.
package rx_buffer_pkg;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned UART_RXBUF_DEPTH = 8;
    localparam int unsigned UART_RXBUF_AW    = 3;

    // Capture handshake with the receive unit; 2'b11 is unused and recovers to WAIT_RS.
    typedef enum logic [1:0] {
        WAIT_RS  = 2'b00,
        ACK      = 2'b01,
        WAIT_CLR = 2'b10
    } rx_cap_state_e;

endpackage

// File: rtl/rx_fifo_core.sv
// Byte storage ring with read/write pointers and occupancy count; show-ahead read port.
module rx_fifo_core
    import rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RXBUF_DEPTH,
    parameter int unsigned AW    = UART_RXBUF_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] dout,
    output logic [AW:0]            count,
    output logic                   empty,
    output logic                   full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic                   wr_ok;
    logic                   rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop on an empty ring is ignored; a write into a full ring needs a same-cycle pop.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // Pointer and count next-state; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer: captures each byte flagged by the receive unit once, acknowledges it,
// and queues it for the CPU. Bytes arriving while full are dropped and flagged.
module rx_buffer
    import rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RXBUF_DEPTH,
    parameter int unsigned AW    = UART_RXBUF_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_rs,
    output logic                   rx_over_read,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overrun,
    input  logic                   clr_err
);

    rx_cap_state_e state_q, state_d;
    logic          rs_q, rs_d;
    logic          rx_over_read_q, rx_over_read_d;
    logic          overrun_q, overrun_d;
    logic          capture;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign rs_d = rx_rs;

    // Capture FSM: take one byte per status assertion, pulse the ack, then wait for status to drop.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            WAIT_RS: begin
                if (rs_q) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!rs_q) begin
                    state_d = WAIT_RS;
                end
            end
            default: begin
                state_d = WAIT_RS;
            end
        endcase
    end

    // Write/drop decision and registered ack/overrun; a drop wins over clr_err.
    always_comb begin
        pop            = rd_en && !empty;
        wr_en          = capture && (!full || pop);
        drop           = capture && !wr_en;
        rx_over_read_d = capture;
        overrun_d      = overrun_q;
        if (clr_err) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_RS;
            rs_q           <= 1'b0;
            rx_over_read_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rs_q           <= rs_d;
            rx_over_read_q <= rx_over_read_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rx_over_read = rx_over_read_q;
    assign overrun      = overrun_q;

    rx_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: handshake, fill/overrun, held status, full push+pop, wrap, reset mid-capture.
module tb_rx_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_over_read;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overrun;
    logic       clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    rx_buffer #(.DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_over_read (rx_over_read),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise status with a byte, wait (bounded) for the ack, drop status, count every ack cycle.
    task automatic send(input logic [7:0] b, output int pulses);
        rx_data = b;
        rx_rs   = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 10 && pulses == 0; i++) begin
            cyc();
            if (rx_over_read) pulses++;
        end
        rx_rs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rx_over_read) pulses++;
        end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        int p;
        rst = 1'b1; rx_data = 8'h00; rx_rs = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) cyc();

        // Reset state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ack", 32'(rx_over_read), 32'd0);
        rst = 1'b0;
        cyc();

        // Single byte
        send(8'hA5, p);
        check("single_pulses", 32'(p), 32'd1);
        check("single_count", 32'(count), 32'd1);
        check("single_dout", 32'(dout), 32'hA5);
        check("single_empty", 32'(empty), 32'd0);
        pop();
        check("single_pop_empty", 32'(empty), 32'd1);
        check("single_pop_count", 32'(count), 32'd0);

        // Fill, then overrun on the ninth byte
        for (int i = 0; i < 8; i++) send(8'(i), p);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_overrun0", 32'(overrun), 32'd0);
        send(8'hFF, p);
        check("ovr_pulses", 32'(p), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(count), 32'd8);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("fill_pop_dout", 32'(dout), 32'(i));
            pop();
        end
        check("fill_drained", 32'(empty), 32'd1);

        // Status held high for 20 cycles
        rx_data = 8'h5A;
        rx_rs   = 1'b1;
        p = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (rx_over_read) p++;
        end
        rx_rs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rx_over_read) p++;
        end
        check("held_pulses", 32'(p), 32'd1);
        check("held_count", 32'(count), 32'd1);
        check("held_dout", 32'(dout), 32'h5A);
        pop();

        // Full with a pop on the same edge as the write
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), p);
        check("fp_full", 32'(full), 32'd1);
        rx_data = 8'h3C;
        rx_rs   = 1'b1;
        cyc();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        rx_rs = 1'b0;
        check("fp_ack", 32'(rx_over_read), 32'd1);
        check("fp_count", 32'(count), 32'd8);
        check("fp_overrun", 32'(overrun), 32'd0);
        repeat (2) cyc();
        for (int i = 1; i < 8; i++) begin
            check("fp_pop_dout", 32'(dout), 32'(8'h10 + i));
            pop();
        end
        check("fp_last_dout", 32'(dout), 32'h3C);
        pop();
        check("fp_drained", 32'(empty), 32'd1);

        // Pointer wrap: 20 write/pop pairs
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h40 + i), p);
            check("wrap_count", 32'(count), 32'd1);
            check("wrap_dout", 32'(dout), 32'(8'h40 + i));
            pop();
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Reset while in ACK with status still high
        rx_data = 8'h77;
        rx_rs   = 1'b1;
        cyc();
        cyc();
        check("racq_ack", 32'(rx_over_read), 32'd1);
        rst = 1'b1;
        cyc();
        check("racq_ack0", 32'(rx_over_read), 32'd0);
        check("racq_count", 32'(count), 32'd0);
        check("racq_empty", 32'(empty), 32'd1);
        check("racq_full", 32'(full), 32'd0);
        check("racq_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        p = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rx_over_read) p++;
        end
        rx_rs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rx_over_read) p++;
        end
        check("racq_pulses", 32'(p), 32'd1);
        check("racq_recount", 32'(count), 32'd1);
        check("racq_dout", 32'(dout), 32'h77);
        pop();

        // clr_err in the same cycle as a drop: set wins
        for (int i = 0; i < 8; i++) send(8'(8'h80 + i), p);
        rx_data = 8'hEE;
        rx_rs   = 1'b1;
        cyc();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        rx_rs   = 1'b0;
        check("clrdrop_overrun", 32'(overrun), 32'd1);
        check("clrdrop_count", 32'(count), 32'd8);
        repeat (2) cyc();
        check("clrdrop_head", 32'(dout), 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_buffer.md
RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of byte entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 3, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from the receive unit.
REQ-006 SHALL have port rx_rs  input  1  receive-status level from the receive unit; high = byte available.
REQ-007 SHALL have port rx_over_read  output  1  one-cycle registered pulse that clears the receive unit's status flag.
REQ-008 SHALL have port rd_en  input  1  CPU pop request.
REQ-009 SHALL have port dout  output  8  oldest buffered byte (show-ahead).
REQ-010 SHALL have port empty  output  1  buffer holds no bytes.
REQ-011 SHALL have port full  output  1  buffer holds DEPTH bytes.
REQ-012 SHALL have port count  output  AW+1  bytes held, 0..DEPTH.
REQ-013 SHALL have port overrun  output  1  sticky flag: a byte was dropped.
REQ-014 SHALL have port clr_err  input  1  clears overrun.

Function
REQ-015 SHALL register rx_rs once into rs_q; all capture decisions use rs_q only.
REQ-016 SHALL implement capture FSM with states WAIT_RS, ACK, WAIT_CLR.
REQ-017 In WAIT_RS with rs_q=1: SHALL write rx_data at wr_ptr if not full (or if full with a simultaneous pop), else drop it and set overrun; next state ACK.
REQ-018 In ACK: SHALL drive rx_over_read=1 for exactly this one cycle; next state WAIT_CLR.
REQ-019 In WAIT_CLR: SHALL stay until rs_q=0, then go to WAIT_RS; no second capture of the same byte is permitted.
REQ-020 Latency: rx_rs rising before edge N causes rs_q=1 after N, write at edge N+1, rx_over_read high in cycle after N+1, byte visible on dout and empty=0 after N+1.
REQ-021 rd_en with empty=0 SHALL advance rd_ptr at the edge; rd_en with empty=1 SHALL be ignored with no state change.
REQ-022 Simultaneous write and pop SHALL leave count unchanged; when full, the pop frees the slot used by the same-cycle write, with no overrun.
REQ-023 Pointers SHALL be AW bits and wrap modulo DEPTH; count SHALL be AW+1 bits and never exceed DEPTH or go below 0.
REQ-024 dout SHALL equal mem[rd_ptr] combinationally; its value when empty=1 is don't-care.
REQ-025 empty = (count==0); full = (count==DEPTH); both derived from registered count.
REQ-026 overrun SHALL set on a dropped byte and clear on clr_err; set wins if both occur in the same cycle.
REQ-027 Invalid FSM encodings SHALL return to WAIT_RS.

Reset
REQ-028 While rst=1, SHALL force rd_ptr=0, wr_ptr=0, count=0, overrun=0, rs_q=0, FSM=WAIT_RS, rx_over_read=0; empty=1, full=0.
REQ-029 Storage array contents SHALL NOT be reset.
REQ-030 Reset asserted mid-capture (ACK or WAIT_CLR) SHALL abandon the handshake; if rx_rs is still high after reset, that byte is captured once via the normal WAIT_RS path.

Structure
REQ-031 FSM state encodings and default DEPTH SHALL live in the shared UART header alongside existing UART constants.
REQ-032 The storage array with pointers and count SHALL be one sub-module, rx_fifo_core; capture FSM and overrun logic stay in rx_buffer.

Verification
REQ-033 Single byte: rx_data=8'hA5, rx_rs pulses high then drops after rx_over_read -> exactly one rx_over_read pulse, count=1, dout=8'hA5, empty=0; rd_en one cycle -> empty=1.
REQ-034 Fill: 8 bytes 8'h00..8'h07 -> full=1, count=8; 9th byte 8'hFF -> dropped, overrun=1, rx_over_read still pulsed; pops return 00..07 in order.
REQ-035 Held status: rx_rs held high for 20 cycles -> one write, one rx_over_read pulse, count=1.
REQ-036 Full with simultaneous pop and write of 8'h3C -> count stays 8, overrun=0, 8'h3C is the last byte popped.
REQ-037 Wrap: 20 write/pop pairs of ascending bytes with DEPTH=8 -> every pop matches in order, count never exceeds 1.
REQ-038 Reset in ACK state with rx_rs high -> all outputs at reset values, then one capture after rst drops; clr_err together with a drop -> overrun=1.
